// File: rtl/snn_axi_cfg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : snn_axi_cfg_slave
//  Purpose  : AXI4-Lite config responder for the SNN core. It holds the
//             CTRL/SIM_TIME/MEM_CFG registers, forwards an external-memory
//             window, and issues a busy-gated network start pulse.
//  Revision : 1.0  initial release
// ============================================================================
module snn_axi_cfg_slave #(
    parameter int                          C_S_AXI_DATA_WIDTH = 32,
    parameter int                          C_S_AXI_ADDR_WIDTH = 16,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] EXT_MEM_OFFSET   = 16'h0100,
    parameter int                          EXT_MEM_ADDR_WIDTH = 12
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            busy,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   debug_in,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   sim_time_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_cfg_reg,
    output logic                            net_start,
    output logic                            mem_wen,
    output logic                            mem_ren,
    output logic [EXT_MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WR_RESP = 2'd1;
    localparam logic [1:0] c_RD_WAIT = 2'd2;
    localparam logic [1:0] c_RD_RESP = 2'd3;

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_CTRL  = C_S_AXI_ADDR_WIDTH'('h0);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_SIM   = C_S_AXI_ADDR_WIDTH'('h4);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_MEM   = C_S_AXI_ADDR_WIDTH'('h8);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_DEBUG = C_S_AXI_ADDR_WIDTH'('hC);

    logic [1:0]                    r_state;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_ctrl;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_sim_time;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem_cfg;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic                          r_net_start;

    logic                          w_idle;
    logic                          w_wr_go;
    logic                          w_rd_go;
    logic                          w_aw_win;
    logic                          w_ar_win;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_aw_off;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_ar_off;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_reg_rdata;
    logic                          w_unused_ok;

    // Handshakes are combinational so accept and commit share one edge;
    // reset masks them so nothing is accepted while it is asserted.
    assign w_idle   = (r_state == c_IDLE) & ~S_AXI_ARESET;
    assign w_wr_go  = w_idle & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_go  = w_idle & S_AXI_ARVALID & ~(S_AXI_AWVALID & S_AXI_WVALID);
    assign w_aw_win = (S_AXI_AWADDR >= EXT_MEM_OFFSET);
    assign w_ar_win = (S_AXI_ARADDR >= EXT_MEM_OFFSET);
    assign w_aw_off = S_AXI_AWADDR - EXT_MEM_OFFSET;
    assign w_ar_off = S_AXI_ARADDR - EXT_MEM_OFFSET;

    assign S_AXI_AWREADY = w_wr_go;
    assign S_AXI_WREADY  = w_wr_go;
    assign S_AXI_ARREADY = w_rd_go;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BVALID  = (r_state == c_WR_RESP);
    assign S_AXI_RVALID  = (r_state == c_RD_RESP);
    assign S_AXI_RDATA   = r_rdata;

    assign mem_wen   = w_wr_go & w_aw_win;
    assign mem_ren   = w_rd_go & w_ar_win;
    assign mem_addr  = mem_wen ? w_aw_off[EXT_MEM_ADDR_WIDTH-1:0] :
                       mem_ren ? w_ar_off[EXT_MEM_ADDR_WIDTH-1:0] : '0;
    assign mem_wdata = mem_wen ? S_AXI_WDATA : '0;

    assign ctrl_reg     = r_ctrl;
    assign sim_time_reg = r_sim_time;
    assign mem_cfg_reg  = r_mem_cfg;
    assign net_start    = r_net_start;

    // Byte strobes are deliberately ignored; window offsets are truncated.
    assign w_unused_ok = ^{S_AXI_WSTRB, w_aw_off, w_ar_off};

    always_comb begin
        w_reg_rdata = '0;
        case (S_AXI_ARADDR)
            c_ADDR_CTRL:  w_reg_rdata = r_ctrl;
            c_ADDR_SIM:   w_reg_rdata = r_sim_time;
            c_ADDR_MEM:   w_reg_rdata = r_mem_cfg;
            c_ADDR_DEBUG: w_reg_rdata = debug_in;
            default:      w_reg_rdata = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state     <= c_IDLE;
            r_ctrl      <= '0;
            r_sim_time  <= '0;
            r_mem_cfg   <= '0;
            r_rdata     <= '0;
            r_net_start <= 1'b0;
        end else begin
            r_net_start <= 1'b0;
            // Start bit is self-clearing at the end of the pulse cycle.
            if (r_net_start) begin
                r_ctrl[0] <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_wr_go) begin
                        r_state <= c_WR_RESP;
                        if (!w_aw_win) begin
                            case (S_AXI_AWADDR)
                                c_ADDR_CTRL: begin
                                    r_ctrl      <= S_AXI_WDATA;
                                    r_net_start <= S_AXI_WDATA[0] & ~busy;
                                end
                                c_ADDR_SIM: r_sim_time <= S_AXI_WDATA;
                                c_ADDR_MEM: r_mem_cfg  <= S_AXI_WDATA;
                                default: ;
                            endcase
                        end
                    end else if (w_rd_go) begin
                        if (w_ar_win) begin
                            r_state <= c_RD_WAIT;
                        end else begin
                            r_rdata <= w_reg_rdata;
                            r_state <= c_RD_RESP;
                        end
                    end
                end
                c_WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_state <= c_IDLE;
                    end
                end
                c_RD_WAIT: begin
                    r_rdata <= mem_rdata;
                    r_state <= c_RD_RESP;
                end
                c_RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snn_axi_cfg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_axi_cfg_slave
//  Purpose  : Directed self-checking bench for snn_axi_cfg_slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snn_axi_cfg_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        busy = 1'b0;
    logic [31:0] debug_in = '0;
    logic [31:0] ctrl_reg, sim_time_reg, mem_cfg_reg, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        net_start, mem_wen, mem_ren;
    logic [11:0] mem_addr;

    logic [31:0] mem_model [0:4095];

    int n_chk = 0;
    int n_err = 0;
    int start_cnt = 0, aw_hi = 0, wen_hi = 0;

    // Per-transaction captures
    logic        wr_wen, wr_start, rd_ren;
    logic [11:0] wr_maddr, rd_maddr;
    logic [31:0] wr_mwdata;
    logic [1:0]  wr_bresp, rd_rresp;
    int          bv_held, rd_lat, rd_unstable;

    always #5 clk = ~clk;

    snn_axi_cfg_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .busy          (busy),
        .debug_in      (debug_in),
        .ctrl_reg      (ctrl_reg),
        .sim_time_reg  (sim_time_reg),
        .mem_cfg_reg   (mem_cfg_reg),
        .net_start     (net_start),
        .mem_wen       (mem_wen),
        .mem_ren       (mem_ren),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Single-port memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_wen) mem_model[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem_model[mem_addr];
    end

    always @(negedge clk) begin
        if (net_start) start_cnt++;
        if (awready)   aw_hi++;
        if (mem_wen)   wen_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input int bdelay);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin n++; @(negedge clk); end
        if (n >= 20) chk("aw_timeout", 32'd0, 32'd1);
        wr_wen = mem_wen; wr_maddr = mem_addr; wr_mwdata = mem_wdata;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        wr_start = net_start;
        bv_held = 0;
        for (int i = 0; i < bdelay; i++) begin
            if (bvalid) bv_held++;
            @(negedge clk);
        end
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin n++; @(negedge clk); end
        if (n >= 20) chk("b_timeout", 32'd0, 32'd1);
        wr_bresp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, input int rdelay, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin n++; @(negedge clk); end
        if (n >= 20) chk("ar_timeout", 32'd0, 32'd1);
        rd_ren = mem_ren; rd_maddr = mem_addr;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        rd_lat = 1;
        while (!rvalid && rd_lat < 20) begin rd_lat++; @(negedge clk); end
        if (rd_lat >= 20) chk("r_timeout", 32'd0, 32'd1);
        d = rdata;
        rd_unstable = 0;
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk);
            if (!rvalid || rdata !== d) rd_unstable++;
        end
        rd_rresp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int s0, a0, w0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", ctrl_reg, 32'h0);
        chk("rst_ready", {29'd0, awready, arready, net_start}, 32'h0);
        chk("rst_valid", {30'd0, bvalid, rvalid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // CTRL write launches the network and self-clears bit0
        s0 = start_cnt; a0 = aw_hi;
        axi_write(16'h0000, 32'hDEADBEEF, 0);
        chk("ctrl_awready_1cyc", 32'(aw_hi - a0), 32'd1);
        chk("ctrl_start_next", {31'd0, wr_start}, 32'd1);
        chk("ctrl_start_once", 32'(start_cnt - s0), 32'd1);
        chk("ctrl_bresp", {30'd0, wr_bresp}, 32'd0);
        axi_read(16'h0000, 0, rd);
        chk("ctrl_rd", rd, 32'hDEADBEEE);
        chk("ctrl_rd_lat", rd_lat, 32'd1);

        axi_write(16'h0004, 32'd100, 0);
        axi_write(16'h0008, 32'h00000301, 0);
        axi_read(16'h0004, 0, rd);
        chk("sim_rd", rd, 32'h64);
        axi_read(16'h0008, 0, rd);
        chk("memcfg_rd", rd, 32'h301);
        chk("sim_out", sim_time_reg, 32'd100);
        chk("memcfg_out", mem_cfg_reg, 32'h301);

        // External memory window
        w0 = wen_hi;
        axi_write(16'h0105, 32'h1FF, 0);
        chk("win_wen", {31'd0, wr_wen}, 32'd1);
        chk("win_wen_1cyc", 32'(wen_hi - w0), 32'd1);
        chk("win_waddr", {20'd0, wr_maddr}, 32'd5);
        chk("win_wdata", wr_mwdata, 32'h1FF);
        axi_read(16'h0105, 0, rd);
        chk("win_ren", {31'd0, rd_ren}, 32'd1);
        chk("win_raddr", {20'd0, rd_maddr}, 32'd5);
        chk("win_rd", rd, 32'h1FF);
        chk("win_rd_lat", rd_lat, 32'd2);

        // Backpressure on both response channels
        axi_read(16'h0008, 5, rd);
        chk("rhold_data", rd, 32'h301);
        chk("rhold_stable", rd_unstable, 32'd0);
        axi_write(16'h0004, 32'd55, 5);
        chk("bhold", bv_held, 32'd5);
        chk("sim_55", sim_time_reg, 32'd55);

        // Simultaneous write + read: write first, read after B handshake
        debug_in = 32'h0000A5A5;
        @(posedge clk); #1;
        awaddr = 16'h0004; wdata = 32'd7; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'h000C; arvalid = 1'b1;
        @(negedge clk);
        chk("pri_awready", {31'd0, awready}, 32'd1);
        chk("pri_arready_lo", {31'd0, arready}, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        chk("pri_bvalid", {31'd0, bvalid}, 32'd1);
        chk("pri_arready_wr", {31'd0, arready}, 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("pri_arready_hi", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        chk("pri_rvalid", {31'd0, rvalid}, 32'd1);
        chk("debug_rd", rdata, 32'h0000A5A5);
        @(posedge clk); #1;
        rready = 1'b0;
        chk("pri_sim", sim_time_reg, 32'd7);

        // Unmapped address
        axi_write(16'h0010, 32'h1234, 0);
        chk("unm_bresp", {30'd0, wr_bresp}, 32'd0);
        axi_read(16'h0010, 0, rd);
        chk("unm_rd", rd, 32'h0);
        chk("unm_rresp", {30'd0, rd_rresp}, 32'd0);

        // Start request while busy is dropped permanently
        busy = 1'b1;
        s0 = start_cnt;
        axi_write(16'h0000, 32'h1, 0);
        busy = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("busy_nostart", 32'(start_cnt - s0), 32'd0);
        chk("busy_bit0", ctrl_reg, 32'h1);

        // Reset in RD_RESP
        @(posedge clk); #1;
        araddr = 16'h0000; arvalid = 1'b1;
        @(negedge clk);
        chk("rr_arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rr_rvalid", {31'd0, rvalid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rr_rvalid_drop", {31'd0, rvalid}, 32'd0);
        chk("rr_ctrl_out", ctrl_reg, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        axi_read(16'h0000, 0, rd);
        chk("rr_ctrl_rd", rd, 32'h0);
        axi_read(16'h0004, 0, rd);
        chk("rr_sim_rd", rd, 32'h0);
        axi_read(16'h0008, 0, rd);
        chk("rr_memcfg_rd", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
